// File: rtl/operand_loader_3328_if.sv
// operand_loader_3328_if: word stream in, assembled operands and adder handshake out.
interface operand_loader_3328_if #(
   parameter int W  = 256,
   parameter int NW = 13
);
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      in_data;
   logic [W*NW-1:0]   a;
   logic [W*NW-1:0]   b;
   logic              add_en;
   logic              add_done;
   logic              busy;
   modport master (output in_valid, in_data, add_done, input in_ready, a, b, add_en, busy);
   modport slave  (input in_valid, in_data, add_done, output in_ready, a, b, add_en, busy);
endinterface

// File: rtl/operand_loader_3328.sv
// operand_loader_3328: streams NW words into a then b, pulses add_en, waits for add_done.
// Define OPLOAD_MSW_FIRST_EN to load the most-significant word first.
module operand_loader_3328 #(
   parameter int W  = 256,
   parameter int NW = 13
) (
   input logic clk,
   input logic rst_n,
   operand_loader_3328_if.slave bus
);
   typedef enum logic [1:0] {LOAD_A, LOAD_B, FIRE, WAIT} state_t;
   localparam logic [3:0] LAST = 4'(NW - 1);
   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d, idx;
   logic [W*NW-1:0] a_q, a_d, b_q, b_d;
   logic            take;
`ifdef OPLOAD_MSW_FIRST_EN
   assign idx = LAST - cnt_q;
`else
   assign idx = cnt_q;
`endif
   // Outputs are gated by rst_n so they are quiet while reset is held.
   assign bus.in_ready = rst_n && (state_q == LOAD_A || state_q == LOAD_B);
   assign bus.add_en   = rst_n && state_q == FIRE;
   assign bus.busy     = rst_n && (state_q == FIRE || state_q == WAIT);
   assign bus.a        = a_q;
   assign bus.b        = b_q;
   assign take         = bus.in_valid && bus.in_ready;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      if (take) cnt_d = (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
      case (state_q)
         LOAD_A: if (take) begin
            a_d[W*idx +: W] = bus.in_data;
            if (cnt_q == LAST) state_d = LOAD_B;
         end
         LOAD_B: if (take) begin
            b_d[W*idx +: W] = bus.in_data;
            if (cnt_q == LAST) state_d = FIRE;
         end
         FIRE:    state_d = WAIT;
         WAIT:    if (bus.add_done) state_d = LOAD_A;
         default: state_d = LOAD_A;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= LOAD_A;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end
endmodule

// File: tb/tb_operand_loader_3328.sv
// tb_operand_loader_3328: directed loads with a scoreboard checking a/b at every add_en.
module tb_operand_loader_3328;
   localparam int W = 256, NW = 13, OPW = W * NW;
   typedef struct {logic [OPW-1:0] a; logic [OPW-1:0] b;} exp_t;
   logic clk = 0, rst_n = 0, model_done = 0, spur = 0;
   logic [OPW:0] sum = '0;
   int n_cmp = 0, n_bad = 0, n_fire = 0, dcnt = 0;
   exp_t q[$];
   exp_t m_e;
   logic [OPW-1:0] va, vb, vc, vd;
   always #5 clk = ~clk;
   operand_loader_3328_if #(.W(W), .NW(NW)) bus();
   operand_loader_3328 #(.W(W), .NW(NW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   assign bus.add_done = model_done | spur;

   task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_op(string nm, logic [OPW-1:0] act, logic [OPW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         for (int i = 0; i < NW; i++)
            if (act[W*i +: W] !== exp[W*i +: W]) begin
               $display("FAIL %s word %0d: got %h expected %h", nm, i, act[W*i +: W], exp[W*i +: W]);
               break;
            end
      end
   endtask

   // Behavioural adder: add_done is high in the third cycle after the add_en cycle.
   always @(posedge clk) begin
      #1;
      if (bus.add_en) begin
         dcnt = 4;
         sum = {1'b0, bus.a} + {1'b0, bus.b};
      end else if (dcnt > 0) dcnt--;
      model_done = (dcnt == 1);
   end

   always @(negedge clk)
      if (rst_n && bus.add_en) begin
         n_fire++;
         if (q.size() == 0) chk("unexpected_add_en", W'(1), W'(0));
         else begin
            m_e = q.pop_front();
            chk_op("sb_a", bus.a, m_e.a);
            chk_op("sb_b", bus.b, m_e.b);
         end
      end

   function automatic int pos(int k);
`ifdef OPLOAD_MSW_FIRST_EN
      return NW - 1 - k;
`else
      return k;
`endif
   endfunction

   task automatic send(logic [W-1:0] d, bit bub);
      int n = 0;
      if (bub) begin
         bus.in_valid = 0;
         @(negedge clk);
      end
      bus.in_valid = 1;
      bus.in_data = d;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) chk("in_ready_timeout", W'(0), W'(1));
      @(negedge clk);
      bus.in_valid = 0;
   endtask

   task automatic load(logic [OPW-1:0] xa, logic [OPW-1:0] xb, bit bub, int spur_beat);
      q.push_back('{a: xa, b: xb});
      for (int k = 0; k < NW; k++) send(xa[W*pos(k) +: W], bub);
      for (int k = 0; k < NW; k++) begin
         if (k == spur_beat) spur = 1;
         send(xb[W*pos(k) +: W], bub);
         spur = 0;
      end
   endtask

   task automatic fire_check(bit spur_fire);
      chk("add_en_after_last_beat", W'(bus.add_en), W'(1));
      chk("busy_fire", W'(bus.busy), W'(1));
      chk("in_ready_fire", W'(bus.in_ready), W'(0));
      spur = spur_fire;
      @(negedge clk);
      spur = 0;
      chk("add_en_single", W'(bus.add_en), W'(0));
      chk("busy_wait", W'(bus.busy), W'(1));
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!bus.add_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) chk("add_done_timeout", W'(0), W'(1));
      @(negedge clk);
      chk("busy_after_done", W'(bus.busy), W'(0));
      chk("in_ready_after_done", W'(bus.in_ready), W'(1));
   endtask

   initial begin
      int n;
      bus.in_valid = 0;
      bus.in_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", W'(bus.in_ready), W'(0));
      chk("rst_add_en", W'(bus.add_en), W'(0));
      chk("rst_busy", W'(bus.busy), W'(0));
      chk_op("rst_a", bus.a, '0);
      rst_n = 1;
      @(negedge clk);
      chk("idle_in_ready", W'(bus.in_ready), W'(1));
      va = '0;
      vb = '0;
      for (int k = 0; k < NW; k++) begin
         va[W*pos(k) +: W] = W'(k + 1);
         vb[W*pos(k) +: W] = W'(32'h100 + k);
      end
      load(va, vb, 0, -1);
      fire_check(0);
`ifdef OPLOAD_MSW_FIRST_EN
      chk("a_low_word", bus.a[W-1:0], W'(13));
      chk("a_high_word", bus.a[OPW-1 -: W], W'(1));
      chk("b_high_word", bus.b[OPW-1 -: W], W'(32'h100));
`else
      chk("a_low_word", bus.a[W-1:0], W'(1));
      chk("a_high_word", bus.a[OPW-1 -: W], W'(13));
      chk("b_high_word", bus.b[OPW-1 -: W], W'(32'h10C));
`endif
      wait_done(n);
      vc = '1;
      vd = OPW'(1);
      load(vc, vd, 0, -1);
      fire_check(0);
      wait_done(n);
      chk("done_latency", W'(n), W'(2));
      chk("adder_c_zero", W'(|sum[OPW-1:0]), W'(0));
      chk_op("a_hold_after_done", bus.a, vc);
      load(va, vb, 1, -1);
      fire_check(0);
      wait_done(n);
      load(vb, va, 0, 5);
      fire_check(1);
      @(negedge clk);
      chk("spurious_still_wait", W'(bus.busy), W'(1));
      wait_done(n);
      load(vc, va, 0, -1);
      fire_check(0);
      rst_n = 0;
      @(negedge clk);
      chk("midrst_in_ready", W'(bus.in_ready), W'(0));
      chk("midrst_busy", W'(bus.busy), W'(0));
      chk_op("midrst_a", bus.a, '0);
      chk_op("midrst_b", bus.b, '0);
      rst_n = 1;
      @(negedge clk);
      chk("postrst_in_ready", W'(bus.in_ready), W'(1));
      @(negedge clk);
      chk("postrst_ignore_done", W'(bus.in_ready), W'(1));
      chk("postrst_add_en", W'(bus.add_en), W'(0));
      load(vb, vc, 1, -1);
      fire_check(0);
      wait_done(n);
      repeat (3) @(negedge clk);
      chk("fire_count", W'(n_fire), W'(6));
      chk("queue_drained", W'(q.size()), W'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
